// File: rtl/ras_pkg.sv
// Shared types and sizing for the return-address stack and its sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ras_pkg;

    // Buffer geometry shared by the RAS buffer instance and the sequencer
    localparam int RAS_SIZE  = 4;
    localparam int RAS_WIDTH = 30;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        RECOVER = 2'd2
    } ras_state_t;

    // Command bundle presented to the LIFO buffer each cycle
    typedef struct packed {
        logic                 push;
        logic                 pop;
        logic                 flush;
        logic [RAS_WIDTH-1:0] data;
    } ras_cmd_t;

endpackage

// File: rtl/ras_depth_ctr.sv
// Saturating shadow depth of the RAS buffer plus sticky overflow flag.
// Latency: depth/overflow update one cycle after the push/pop/clr command.
// Backpressure: none; a push at full saturates depth and sets overflow.
module ras_depth_ctr
    import ras_pkg::*;
#(
    parameter int SIZE = RAS_SIZE
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clr,
    input  logic                   push,
    input  logic                   pop,
    output logic [$clog2(SIZE):0]  depth,
    output logic                   overflow
);
    localparam int PTRW = $clog2(SIZE);
    localparam logic [PTRW:0] DEPTH_MAX = (PTRW+1)'(SIZE);

    logic full;
    logic empty;

    assign full  = (depth == DEPTH_MAX);
    assign empty = (depth == '0);

    // Depth tracks buffer occupancy; push+pop together is a top replace
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            depth    <= '0;
            overflow <= 1'b0;
        end else if (push && !pop) begin
            if (full) begin
                // Oldest entry is overwritten in the buffer; depth pinned
                overflow <= 1'b1;
            end else begin
                depth <= depth + 1'b1;
            end
        end else if (pop && !push && !empty) begin
            depth <= depth - 1'b1;
        end
    end

endmodule

// File: rtl/ras_sequencer.sv
// Turns fetch call/return hints into RAS buffer push/pop/flush and gates prediction; optional RAS_SEQ_STATS_EN adds counters.
// Latency: commands and prediction are combinational; state/depth update on the next edge.
// Backpressure: none; underflow pops are dropped, overflow overwrites the oldest entry.
module ras_sequencer
    import ras_pkg::*;
#(
    parameter int SIZE        = RAS_SIZE,
    parameter int WIDTH       = RAS_WIDTH,
    parameter int RECOVER_CYC = 2
) (
    input  logic             s_clk_i,
    input  logic             s_reset_i,
    input  logic             s_enable_i,
    input  logic             s_fire_i,
    input  logic             s_call_i,
    input  logic             s_ret_i,
    input  logic [WIDTH-1:0] s_ret_addr_i,
    input  logic             s_redirect_i,
    input  logic             s_buf_empty_i,
    input  logic [WIDTH-1:0] s_buf_data_i,
    output logic             s_buf_push_o,
    output logic             s_buf_pop_o,
    output logic             s_buf_flush_o,
    output logic [WIDTH-1:0] s_buf_data_o,
    output logic             s_pred_valid_o,
    output logic [WIDTH-1:0] s_pred_addr_o,
    output logic             s_overflow_o
`ifdef RAS_SEQ_STATS_EN
    ,
    output logic [15:0]      s_stat_ovf_o,
    output logic [15:0]      s_stat_unf_o
`endif
);
    localparam int PTRW = $clog2(SIZE);
    localparam int CNTW = (RECOVER_CYC > 1) ? $clog2(RECOVER_CYC) : 1;
    localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(RECOVER_CYC - 1);

    ras_state_t      state_q;
    ras_state_t      state_d;
    logic [CNTW-1:0] cnt_q;
    logic [CNTW-1:0] cnt_d;
    ras_cmd_t        cmd;
    logic [PTRW:0]   depth;
    logic            depth_zero;
    logic            hint_ok;
    logic            call_only;
    logic            ret_only;
    logic            swap;

    // Hints only count in RUN, when accepted, not squashed by redirect or reset
    assign hint_ok    = (state_q == RUN) && s_fire_i && !s_redirect_i && !s_reset_i;
    assign call_only  = hint_ok && s_call_i && !s_ret_i;
    assign ret_only   = hint_ok && s_ret_i && !s_call_i;
    assign swap       = hint_ok && s_call_i && s_ret_i;
    assign depth_zero = (depth == '0);

    // State register and recovery counter
    always_ff @(posedge s_clk_i) begin
        if (s_reset_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: redirect beats disable; redirect in RECOVER restarts the wait
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (s_enable_i) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (s_redirect_i) begin
                    state_d = RECOVER;
                    cnt_d   = CNT_LOAD;
                end else if (!s_enable_i) begin
                    state_d = IDLE;
                end
            end
            RECOVER: begin
                if (s_redirect_i) begin
                    cnt_d = CNT_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = s_enable_i ? RUN : IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode: buffer held flushed outside RUN; pop suppressed at depth 0
    always_comb begin
        cmd       = '0;
        cmd.flush = (state_q != RUN);
        cmd.push  = call_only || swap;
        cmd.pop   = (ret_only || swap) && !depth_zero;
        cmd.data  = RAS_WIDTH'(s_ret_addr_i);
    end

    assign s_buf_push_o   = cmd.push;
    assign s_buf_pop_o    = cmd.pop;
    assign s_buf_flush_o  = cmd.flush;
    assign s_buf_data_o   = WIDTH'(cmd.data);
    assign s_pred_addr_o  = s_buf_data_i;
    // Both shadow depth and buffer flag must agree before a prediction is used
    assign s_pred_valid_o = (state_q == RUN) && !depth_zero && !s_buf_empty_i && !s_redirect_i;

    ras_depth_ctr #(
        .SIZE (SIZE)
    ) u_depth_ctr (
        .clk      (s_clk_i),
        .reset    (s_reset_i),
        .clr      (cmd.flush),
        .push     (cmd.push),
        .pop      (cmd.pop),
        .depth    (depth),
        .overflow (s_overflow_o)
    );

`ifdef RAS_SEQ_STATS_EN
    logic depth_full;
    logic ovf_evt;
    logic unf_evt;

    assign depth_full = (depth == (PTRW+1)'(SIZE));
    assign ovf_evt    = cmd.push && !cmd.pop && depth_full;
    assign unf_evt    = ret_only && depth_zero;

    // Saturating event counters; survive flushes, cleared only by reset
    always_ff @(posedge s_clk_i) begin
        if (s_reset_i) begin
            s_stat_ovf_o <= '0;
            s_stat_unf_o <= '0;
        end else begin
            if (ovf_evt && (s_stat_ovf_o != 16'hFFFF)) begin
                s_stat_ovf_o <= s_stat_ovf_o + 16'd1;
            end
            if (unf_evt && (s_stat_unf_o != 16'hFFFF)) begin
                s_stat_unf_o <= s_stat_unf_o + 16'd1;
            end
        end
    end
`endif

endmodule

// File: doc/ras_sequencer.md
Name: ras_sequencer

Overview:
- Controller that drives the return-address LIFO (circular_buffer, LIFO top-of-stack read) from fetch-stage call/return hints.
- Converts hints into push/pop/flush commands and keeps a saturating shadow depth, so pops on an empty stack are suppressed.
- Gates the predicted return address and runs a recovery sequence on pipeline redirect.
- Sits between the fetch predictor and the RAS buffer instance.

Parameters:
- SIZE, 4, number of buffer entries; must match the attached buffer, power of two, at least 2.
- WIDTH, 30, return-address width (word address).
- RECOVER_CYC, 2, cycles spent in RECOVER after a redirect, at least 1.

Ports:
- s_clk_i  in  1  clock.
- s_reset_i  in  1  synchronous reset, active-high.
- s_enable_i  in  1  RAS enable (CSR); low forces IDLE.
- s_fire_i  in  1  fetch accepted the current hint.
- s_call_i  in  1  hinted instruction is a call.
- s_ret_i  in  1  hinted instruction is a return.
- s_ret_addr_i  in  WIDTH  return address to push on a call.
- s_redirect_i  in  1  pipeline redirect/mispredict flush.
- s_buf_empty_i  in  1  buffer empty flag.
- s_buf_data_i  in  WIDTH  buffer top-of-stack.
- s_buf_push_o  out  1  buffer push.
- s_buf_pop_o  out  1  buffer pop.
- s_buf_flush_o  out  1  buffer flush.
- s_buf_data_o  out  WIDTH  data to push.
- s_pred_valid_o  out  1  prediction usable.
- s_pred_addr_o  out  WIDTH  predicted return address.
- s_overflow_o  out  1  sticky: stack has overflowed since last flush.

Behaviour:
- FSM states IDLE, RUN, RECOVER. Reset: state IDLE, depth 0, overflow 0, recover counter 0.
- IDLE:
  - s_buf_flush_o=1; push, pop and pred_valid are 0.
  - Goes to RUN in the cycle after s_enable_i=1.
- RUN:
  - s_buf_flush_o=0.
  - s_redirect_i=1 -> RECOVER, counter loaded with RECOVER_CYC-1. Hints in that cycle are ignored.
  - s_enable_i=0 -> IDLE. Redirect has priority over disable.
- RECOVER:
  - s_buf_flush_o=1 on every cycle; depth and overflow cleared.
  - Counter decrements; at 0 -> RUN, or IDLE if s_enable_i=0.
  - A redirect arriving during RECOVER reloads the counter.
- Commands are combinational, issued only in RUN with s_fire_i=1 and no redirect:
  - call only: push=1, s_buf_data_o=s_ret_addr_i; depth+1, saturating at SIZE. Push while depth==SIZE sets overflow; the oldest entry is overwritten.
  - ret only with depth>0: pop=1; depth-1.
  - ret only with depth==0: no pop (underflow suppressed).
  - call and ret together (coroutine swap): push=1 and pop=1, top replaced, depth unchanged. At depth 0: push only, depth becomes 1.
- s_pred_addr_o = s_buf_data_i, combinational.
- s_pred_valid_o = (state==RUN) & depth!=0 & ~s_buf_empty_i & ~s_redirect_i.
- Depth counter is PTRW+1 bits, PTRW=$clog2(SIZE); it never exceeds SIZE and never wraps below 0.
- Mismatch between depth!=0 and s_buf_empty_i: the valid term uses both, so prediction stays safe.
- Synchronous reset mid-operation: outputs take IDLE values from the next edge. Commands are blocked while s_reset_i=1, since reset has priority.

Optional Feature:
- Macro RAS_SEQ_STATS_EN.
- Defined:
  - Adds outputs s_stat_ovf_o and s_stat_unf_o, each 16 bits, saturating.
  - s_stat_ovf_o counts pushes at depth==SIZE; s_stat_unf_o counts suppressed underflow pops.
  - Both cleared only by reset, not by flush.
- Not defined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package ras_pkg:
  - ras_state_t enum (IDLE, RUN, RECOVER).
  - ras_cmd_t struct (push, pop, flush, data).
  - Constants RAS_SIZE and RAS_WIDTH used by both buffer and sequencer.
- Natural sub-module: ras_depth_ctr, the saturating up/down depth counter with overflow flag.
- The circular_buffer instance stays outside, in the fetch top.

Test Plan:
- Reset then enable=1 -> one IDLE cycle with flush=1, then RUN; pred_valid=0 and depth 0.
- Calls 0x100, 0x200, 0x300 each with fire=1, then three rets -> pops issued in order, pred_addr 0x300, 0x200, 0x100; pred_valid falls after the third.
- Five calls with SIZE=4 -> overflow rises on the 5th push and depth stays 4; four rets give the top four addresses; a 5th ret gives no pop.
- Call+ret same cycle at depth 2 (ret_addr 0x440) -> push and pop both high, depth stays 2, next pred_addr 0x440; at depth 0 -> push only, depth 1.
- Redirect during a call at depth 3 -> no push; RECOVER for RECOVER_CYC=2 cycles with flush=1; then RUN with depth 0, overflow 0, pred_valid 0.
- With RAS_SEQ_STATS_EN: 2 overflowing pushes and 3 empty rets -> s_stat_ovf_o=2, s_stat_unf_o=3; both counts survive a redirect.
